// File: rtl/mini_alu_pipe.sv
// 2-stage (fetch/execute) mini ALU with X->F operand bypass; MUL only when MINI_ALU_PIPE_MUL_EN is defined.
// Latency: one cycle F->X; dependent back-to-back instructions never stall, taken branch costs one bubble.
// Backpressure: iEnable=0 freezes every register and blocks register-file writes; no internal stalls.
module mini_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iEnable,
    input  logic [4+3*ADDR_W-1:0]   iInstruction,
    output logic [IP_W-1:0]         oIP,
    output logic [LED_W-1:0]        oLed,
    output logic                    oHalted,
    output logic                    oRetire
);

    localparam int IW = 4 + 3 * ADDR_W;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_STO  = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_LED  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;

    logic [DATA_W-1:0] rf_q [2**ADDR_W];

    logic [IW-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0] op0_q, op0_d, op1_q, op1_d;
    logic [IP_W-1:0]   ip_q, ip_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              halted_q, halted_d;

    logic [3:0]        x_op;
    logic [ADDR_W-1:0] x_dst, x_src1, x_src0;
    logic [ADDR_W-1:0] f_src1, f_src0;
    logic [DATA_W-1:0] x_res;
    logic              x_we, x_branch, x_led, x_halt, x_retire;

    assign x_op   = ir_q[IW-1 -: 4];
    assign x_dst  = ir_q[3*ADDR_W-1 -: ADDR_W];
    assign x_src1 = ir_q[2*ADDR_W-1 -: ADDR_W];
    assign x_src0 = ir_q[ADDR_W-1:0];
    assign f_src1 = iInstruction[2*ADDR_W-1 -: ADDR_W];
    assign f_src0 = iInstruction[ADDR_W-1:0];

`ifdef MINI_ALU_PIPE_MUL_EN
    logic signed [2*DATA_W-1:0] mul_prod;
    assign mul_prod = $signed(op1_q) * $signed(op0_q);
`endif

    // Execute stage decode; OP1 carries src1 data (D1), OP0 carries src0 data (D0).
    always_comb begin
        x_res    = '0;
        x_we     = 1'b0;
        x_branch = 1'b0;
        x_led    = 1'b0;
        x_halt   = 1'b0;
        x_retire = 1'b0;
        case (x_op)
            OP_ADD:  begin x_res = op1_q + op0_q; x_we = 1'b1; x_retire = 1'b1; end
            OP_SUB:  begin x_res = op1_q - op0_q; x_we = 1'b1; x_retire = 1'b1; end
            OP_AND:  begin x_res = op1_q & op0_q; x_we = 1'b1; x_retire = 1'b1; end
            OP_OR:   begin x_res = op1_q | op0_q; x_we = 1'b1; x_retire = 1'b1; end
            OP_STO:  begin x_res = DATA_W'({x_src1, x_src0}); x_we = 1'b1; x_retire = 1'b1; end
`ifdef MINI_ALU_PIPE_MUL_EN
            OP_MUL:  begin x_res = mul_prod[DATA_W-1:0]; x_we = 1'b1; x_retire = 1'b1; end
`endif
            OP_BLE:  begin x_branch = (op1_q <= op0_q); x_retire = 1'b1; end
            OP_JMP:  begin x_branch = 1'b1; x_retire = 1'b1; end
            OP_LED:  begin x_led = 1'b1; x_retire = 1'b1; end
            OP_HALT: begin x_halt = 1'b1; x_retire = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        ir_d     = ir_q;
        op0_d    = op0_q;
        op1_d    = op1_q;
        ip_d     = ip_q;
        led_d    = led_q;
        halted_d = halted_q;
        if (iEnable) begin
            if (halted_q || x_halt) begin
                ir_d = '0;
            end else if (x_branch) begin
                ip_d = IP_W'(x_dst);
                ir_d = '0;
            end else begin
                ip_d = ip_q + IP_W'(1);
                ir_d = iInstruction;
            end
            // Bypass: the result being written this edge wins over the stale file entry.
            op0_d    = (x_we && (x_dst == f_src0)) ? x_res : rf_q[f_src0];
            op1_d    = (x_we && (x_dst == f_src1)) ? x_res : rf_q[f_src1];
            led_d    = x_led ? op1_q[LED_W-1:0] : led_q;
            halted_d = halted_q | x_halt;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ir_q     <= '0;
            op0_q    <= '0;
            op1_q    <= '0;
            ip_q     <= '0;
            led_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            op0_q    <= op0_d;
            op1_q    <= op1_d;
            ip_q     <= ip_d;
            led_q    <= led_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (iEnable && x_we) begin
            rf_q[x_dst] <= x_res;
        end
    end

    assign oIP     = ip_q;
    assign oLed    = led_q;
    assign oHalted = halted_q;
    assign oRetire = iEnable & x_retire;

endmodule

// File: tb/tb_mini_alu_pipe.sv
// Randomized and directed bench for mini_alu_pipe against an instruction-level reference model.
module tb_mini_alu_pipe;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iEnable = 1'b0;
    logic [27:0] iInstruction;
    logic [15:0] oIP;
    logic [7:0]  oLed;
    logic        oHalted;
    logic        oRetire;

    logic [27:0] rom [256];
    assign iInstruction = rom[oIP[7:0]];

    mini_alu_pipe dut (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iInstruction(iInstruction),
        .oIP(oIP), .oLed(oLed), .oHalted(oHalted), .oRetire(oRetire)
    );

    always #5 Clock = ~Clock;

`ifdef MINI_ALU_PIPE_MUL_EN
    localparam bit          MUL_ON  = 1'b1;
    localparam logic [7:0]  MUL_LED = 8'hF2;
`else
    localparam bit          MUL_ON  = 1'b0;
    localparam logic [7:0]  MUL_LED = 8'h33;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state plus the single instruction waiting to execute.
    logic [15:0] m_rf [256];
    logic [15:0] m_ip;
    logic [27:0] m_xw;
    bit          m_xv;
    logic [7:0]  m_led;
    bit          m_halted;

    int          cyc;
    int          ret_cnt;
    logic [15:0] ip_log [64];
    bit          ret_log [64];

    function automatic logic [27:0] enc(input int op, input int dst, input int s1, input int s0);
        logic [3:0] o; logic [7:0] d, a, b;
        o = op[3:0]; d = dst[7:0]; a = s1[7:0]; b = s0[7:0];
        return {o, d, a, b};
    endfunction

    function automatic bit retires(input logic [27:0] w);
        int op;
        op = int'(w[27:24]);
        if (op == 3) return MUL_ON;
        return (op >= 1 && op <= 10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ip = '0; m_xv = 0; m_xw = '0; m_led = '0; m_halted = 0;
    endtask

    task automatic model_step();
        int op, dst, s1, s0;
        logic [15:0] d1, d0;
        logic signed [31:0] prod;
        bit br, hlt;
        br = 0; hlt = 0;
        if (m_xv) begin
            op = int'(m_xw[27:24]); dst = int'(m_xw[23:16]);
            s1 = int'(m_xw[15:8]);  s0 = int'(m_xw[7:0]);
            d1 = m_rf[s1]; d0 = m_rf[s0];
            case (op)
                1: m_rf[dst] = d1 + d0;
                2: m_rf[dst] = d1 - d0;
                3: if (MUL_ON) begin prod = $signed({{16{d1[15]}}, d1}) * $signed({{16{d0[15]}}, d0}); m_rf[dst] = prod[15:0]; end
                4: m_rf[dst] = {m_xw[15:8], m_xw[7:0]};
                5: br = (d1 <= d0);
                6: br = 1;
                7: m_led = d1[7:0];
                8: m_rf[dst] = d1 & d0;
                9: m_rf[dst] = d1 | d0;
                10: hlt = 1;
                default: ;
            endcase
        end
        if (m_halted || hlt) begin
            m_xv = 0;
        end else if (br) begin
            m_ip = {8'h00, m_xw[23:16]};
            m_xv = 0;
        end else begin
            m_xw = rom[m_ip[7:0]];
            m_xv = 1;
            m_ip = m_ip + 16'd1;
        end
        if (hlt) m_halted = 1;
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge Clock);
        chk("oIP", 32'(oIP), 32'(m_ip));
        chk("oLed", 32'(oLed), 32'(m_led));
        chk("oHalted", 32'(oHalted), 32'(m_halted));
        chk("oRetire", 32'(oRetire), 32'(iEnable && Reset && m_xv && retires(m_xw)));
        if (cyc < 64) begin ip_log[cyc] = oIP; ret_log[cyc] = oRetire; end
        if (oRetire) ret_cnt++;
        @(posedge Clock);
        if (Reset && iEnable) model_step();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        model_reset();
        cycle();
        cycle();
        Reset = 1'b1;
        cyc = 0;
        ret_cnt = 0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic run(input int n);
        iEnable = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_fwd_prog();
        clear_rom();
        rom[0] = enc(4, 1, 8'h00, 8'h05);
        rom[1] = enc(4, 2, 8'h00, 8'h03);
        rom[2] = enc(1, 3, 2, 1);
        rom[3] = enc(7, 0, 3, 0);
    endtask

    task automatic gen_random_prog();
        int op;
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = enc(4, i, $urandom_range(0, 255), $urandom_range(0, 255));
        for (int i = 8; i < 64; i++) begin
            op = $urandom_range(0, 15);
            if (op == 10 && $urandom_range(0, 3) != 0) op = 1;
            if (op == 5 || op == 6)
                rom[i] = enc(op, $urandom_range(8, 63), $urandom_range(0, 7), $urandom_range(0, 7));
            else if (op == 4)
                rom[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            else
                rom[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        end
    endtask

    initial begin
        cyc = 0;
        ret_cnt = 0;
        for (int i = 0; i < 256; i++) m_rf[i] = '0;
        clear_rom();
        model_reset();

        // Reset state
        #2;
        chk("reset_oIP", 32'(oIP), 32'h0);
        chk("reset_oLed", 32'(oLed), 32'h0);
        chk("reset_oHalted", 32'(oHalted), 32'h0);
        chk("reset_oRetire", 32'(oRetire), 32'h0);

        // Forwarding chain with no stalls
        load_fwd_prog();
        do_reset();
        run(8);
        chk("fwd_led", 32'(oLed), 32'h08);
        chk("fwd_retires", 32'(ret_cnt), 32'd4);
        chk("fwd_model_r3", 32'(m_rf[3]), 32'h0008);

        // Subtraction wraps modulo 2^16
        clear_rom();
        rom[0] = enc(4, 1, 0, 5);
        rom[1] = enc(4, 2, 0, 3);
        rom[2] = enc(2, 4, 2, 1);
        rom[3] = enc(7, 0, 4, 0);
        do_reset();
        run(8);
        chk("sub_led", 32'(oLed), 32'hFE);
        chk("sub_model_r4", 32'(m_rf[4]), 32'hFFFE);

        // Taken branch: one bubble, the shadow instruction never retires
        clear_rom();
        rom[0]    = enc(4, 1, 0, 5);
        rom[1]    = enc(4, 2, 0, 2);
        rom[6]    = enc(5, 8'h10, 2, 1);
        rom[7]    = enc(7, 0, 1, 0);
        rom[8'h10] = enc(7, 0, 2, 0);
        do_reset();
        run(14);
        chk("br_ip6", 32'(ip_log[6]), 32'h06);
        chk("br_ip7", 32'(ip_log[7]), 32'h07);
        chk("br_ip10", 32'(ip_log[8]), 32'h10);
        chk("br_ip11", 32'(ip_log[9]), 32'h11);
        chk("br_squash_retire", 32'(ret_log[8]), 32'h0);
        chk("br_led", 32'(oLed), 32'h02);

        // Multiply (signed, low half) or NOP when the multiplier is absent
        clear_rom();
        rom[0] = enc(4, 1, 8'h00, 8'h07);
        rom[1] = enc(4, 2, 8'hFF, 8'hFE);
        rom[2] = enc(4, 5, 8'h00, 8'h33);
        rom[3] = enc(3, 5, 2, 1);
        rom[4] = enc(7, 0, 5, 0);
        do_reset();
        run(9);
        chk("mul_led", 32'(oLed), 32'(MUL_LED));

        // Enable gaps between dependent instructions
        load_fwd_prog();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            iEnable = !(i >= 3 && i <= 5);
            cycle();
        end
        chk("en_led", 32'(oLed), 32'h08);
        chk("en_retires", 32'(ret_cnt), 32'd4);

        // HALT: prior instruction completes, fetch address freezes
        clear_rom();
        rom[0]  = enc(4, 1, 0, 8'h11);
        rom[1]  = enc(4, 2, 0, 8'h22);
        rom[8]  = enc(7, 0, 2, 0);
        rom[9]  = enc(10, 0, 0, 0);
        rom[10] = enc(7, 0, 1, 0);
        do_reset();
        run(20);
        chk("halt_ip", 32'(oIP), 32'h0A);
        chk("halt_flag", 32'(oHalted), 32'h1);
        chk("halt_led", 32'(oLed), 32'h22);

        // Asynchronous reset between edges
        load_fwd_prog();
        do_reset();
        run(6);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_ip", 32'(oIP), 32'h0);
        chk("async_rst_led", 32'(oLed), 32'h0);
        chk("async_rst_retire", 32'(oRetire), 32'h0);
        model_reset();
        do_reset();
        run(4);

        // Random programs with random enable gaps
        for (int p = 0; p < 20; p++) begin
            gen_random_prog();
            do_reset();
            for (int i = 0; i < 300; i++) begin
                iEnable = ($urandom_range(0, 9) != 0);
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mini_alu_pipe.md
MINI_ALU_PIPE -- requirements
Module: mini_alu_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, datapath and register width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, register-file address width; the file holds 2^ADDR_W entries.
REQ-003 The block SHALL have parameter IP_W, default 16, instruction-pointer width.
REQ-004 The block SHALL have parameter LED_W, default 8, LED output width, with LED_W <= DATA_W.
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port iEnable, input, 1 bit: pipeline advance; 0 freezes all state.
REQ-008 The block SHALL have port iInstruction, input, 4+3*ADDR_W bits: the instruction word {op[3:0], dst, src1, src0}, supplied combinationally by an external ROM at oIP.
REQ-009 The block SHALL have port oIP, output, IP_W bits: the registered fetch address.
REQ-010 The block SHALL have port oLed, output, LED_W bits: the registered LED value.
REQ-011 The block SHALL have port oHalted, output, 1 bit: high after HALT executes.
REQ-012 The block SHALL have port oRetire, output, 1 bit: one-cycle pulse for each non-squashed, non-NOP instruction completing execute.

Function
REQ-013 The block SHALL be a 2-stage pipeline: F (oIP presented, operands read) and X (execute/write), with IR, OP0 and OP1 registered at the F-to-X edge.
REQ-014 The block SHALL use these opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 STO, 5 BLE, 6 JMP, 7 LED, 8 AND, 9 OR, 10 HALT; codes 11 to 15 SHALL execute as NOP.
REQ-015 ADD, SUB, AND and OR SHALL compute RF[dst] <= D1 op D0, where D1 is the src1 data and D0 the src0 data; SUB is D1-D0; results are DATA_W-bit modulo with carry discarded.
REQ-016 STO SHALL write RF[dst] <= {src1,src0}, zero-extended or truncated to DATA_W.
REQ-017 LED SHALL load oLed <= D1[LED_W-1:0] at the end of X and SHALL NOT write the register file.
REQ-018 BLE SHALL branch to dst, zero-extended to IP_W, when D1 <= D0 (unsigned); JMP SHALL branch to dst unconditionally.
REQ-019 On a taken branch, the instruction fetched in the same cycle SHALL be squashed (IR <= NOP) and oIP SHALL be loaded with the target, giving exactly one bubble.
REQ-020 When no branch is taken, oIP SHALL increment by 1 per enabled cycle and wrap modulo 2^IP_W.
REQ-021 Bypass: when the X-stage write address equals a src address being read in F in the same cycle, the operand register SHALL capture the X result and not the register-file content.
REQ-022 Back-to-back dependent instructions SHALL produce results identical to sequential execution, with no stall cycles.
REQ-023 With iEnable=0, oIP, IR, OP0, OP1, oLed and oHalted SHALL hold, there SHALL be no register-file write, and oRetire SHALL be 0.
REQ-024 HALT SHALL set oHalted=1; oIP SHALL then freeze, IR SHALL load NOP every cycle, and only reset SHALL clear oHalted.
REQ-025 An instruction in X when HALT is fetched SHALL still complete.
REQ-026 A taken branch or HALT in X SHALL take priority over the incrementing oIP.

Reset
REQ-027 Asserting Reset SHALL immediately and asynchronously force oIP=0, IR=NOP, OP0=OP1=0, oLed=0, oHalted=0 and oRetire=0.
REQ-028 The register file SHALL NOT be reset, and its contents SHALL be undefined until written.
REQ-029 Reset asserted mid-operation SHALL abort the X-stage write.
REQ-030 After Reset deassertion, the first fetch SHALL be from address 0 on the first enabled edge.

Configuration
REQ-031 With macro MINI_ALU_PIPE_MUL_EN defined, MUL SHALL write RF[dst] <= the low DATA_W bits of the signed product D1*D0.
REQ-032 With MINI_ALU_PIPE_MUL_EN undefined, no multiplier SHALL be synthesised and opcode 3 SHALL execute as NOP, with no write and oRetire=0.

Verification
REQ-033 Forwarding: STO r1,0x0005; STO r2,0x0003; ADD r3=r2+r1; LED r3, all back-to-back -> oLed=0x08 and 4 oRetire pulses.
REQ-034 SUB wrap: r1=5, r2=3; SUB r4=r2-r1; LED r4 -> oLed=0xFE, and r4 SHALL read 0xFFFE.
REQ-035 Branch: r1=5, r2=2; BLE dst=0x10 at address 6 -> oIP sequence 6,7,0x10,0x11; the instruction at 7 SHALL NOT retire.
REQ-036 MUL: r1=0x0007, r2=0xFFFE; MUL r5; LED r5 -> with macro, oLed=0xF2; without macro, r5 SHALL be unchanged.
REQ-037 Enable/halt: iEnable=0 for 3 cycles between dependent ADDs -> results identical to REQ-033; HALT at address 9 -> oIP stays 0x0A and oHalted=1.
REQ-038 Reset mid-run: Reset low between edges -> oIP=0 and oLed=0 before the next Clock edge.
